nav_msg_gen: RTL and testbench

//  Generates the 50 bps GPS L1 C/A navigation data bit stream that drives gps_gen_core.msg_in.
//  Bit timing is locked to the core's C/A epoch pulse (start_out, one pulse per 1 ms code period).

---
 rtl/nav_msg_gen.sv | 229 ++++++++++++++++++++++
 tb/tb_nav_msg_gen.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nav_msg_gen.sv
// Navigation data bit generator for the GPS L1 C/A signal generator core.
// Emits one data bit every EPOCHS_PER_BIT C/A epochs. In preset mode it builds
// subframes (TLM, HOW with running TOW and subframe ID, zero payload) with
// full word parity; otherwise it re-times the synchronised external pin bit.
// Ports:
//   clk_in / rst_in_n       clock, synchronous active-low reset
//   ena_in                  enable; low forces IDLE and clears framing
//   epoch_in                1-cycle C/A epoch pulse
//   preset_in               1 = internal subframes, 0 = pass ext_msg_in
//   ext_msg_in              asynchronous external data bit
//   tlm_in, tow_init_in     TLM field, initial TOW count
//   msg_out                 data bit to core
//   bit_strobe_out          pulse on every msg_out update
//   subframe_start_out      pulse on the first bit of each subframe
//   tow_out                 TOW count of the current subframe
module nav_msg_gen #(
  parameter int unsigned EPOCHS_PER_BIT = 20,
  parameter int unsigned TOW_MAX        = 100799
) (
  input  logic        clk_in,
  input  logic        rst_in_n,
  input  logic        ena_in,
  input  logic        epoch_in,
  input  logic        preset_in,
  input  logic        ext_msg_in,
  input  logic [13:0] tlm_in,
  input  logic [16:0] tow_init_in,
  output logic        msg_out,
  output logic        bit_strobe_out,
  output logic        subframe_start_out,
  output logic [16:0] tow_out
);

  localparam int unsigned     EpochW    = $clog2(EPOCHS_PER_BIT);
  localparam logic [EpochW-1:0] EpochLast = EpochW'(EPOCHS_PER_BIT - 1);
  localparam logic [16:0]     TowLast   = 17'(TOW_MAX);
  localparam logic [7:0]      Preamble  = 8'b1000_1011;

  typedef enum logic [1:0] {StIdle, StArm, StRun} state_e;

  state_e              state_q, state_d;
  logic [EpochW-1:0]   epoch_cnt_q, epoch_cnt_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [3:0]          word_cnt_q, word_cnt_d;
  logic [2:0]          sf_id_q, sf_id_d;
  logic [16:0]         tow_q, tow_d;
  logic [16:0]         tow_out_q, tow_out_d;
  logic                d29_q, d29_d, d30_q, d30_d;
  logic [29:0]         sr_q, sr_d;
  logic                msg_q, msg_d;
  logic                strobe_q, strobe_d;
  logic                sf_start_q, sf_start_d;
  logic                ext_meta_q, ext_sync_q;

  logic [3:0]          word_sel;
  logic [23:0]         word_data;
  logic [29:0]         word_tx;
  logic [16:0]         tow_inc;
  logic [2:0]          sf_id_inc;
  logic                load, shift, tx_bit;

  // D25..D30 from the data bits and the previous word's D29*/D30*.
  function automatic logic [5:0] gps_parity(input logic [23:0] data, input logic p29,
                                            input logic p30);
    logic [24:1] d;
    logic [5:0]  p;
    for (int i = 1; i <= 24; i++) d[i] = data[24-i];  // d[i] is Di, D1 = MSB
    p[5] = p29 ^ d[1] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14]
         ^ d[17] ^ d[18] ^ d[20] ^ d[23];
    p[4] = p30 ^ d[2] ^ d[3] ^ d[4] ^ d[6] ^ d[7] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15]
         ^ d[18] ^ d[19] ^ d[21] ^ d[24];
    p[3] = p29 ^ d[1] ^ d[3] ^ d[4] ^ d[5] ^ d[7] ^ d[8] ^ d[12] ^ d[13] ^ d[14] ^ d[15]
         ^ d[16] ^ d[19] ^ d[20] ^ d[22];
    p[2] = p30 ^ d[2] ^ d[4] ^ d[5] ^ d[6] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^ d[16]
         ^ d[17] ^ d[20] ^ d[21] ^ d[23];
    p[1] = p30 ^ d[1] ^ d[3] ^ d[5] ^ d[6] ^ d[7] ^ d[9] ^ d[10] ^ d[14] ^ d[15] ^ d[16]
         ^ d[17] ^ d[18] ^ d[21] ^ d[22] ^ d[24];
    p[0] = p29 ^ d[3] ^ d[5] ^ d[6] ^ d[8] ^ d[9] ^ d[10] ^ d[11] ^ d[13] ^ d[15] ^ d[19]
         ^ d[22] ^ d[23] ^ d[24];
    return p;
  endfunction

  assign tow_inc   = (tow_q == TowLast) ? 17'd0 : tow_q + 17'd1;
  assign sf_id_inc = (sf_id_q == 3'd5) ? 3'd1 : sf_id_q + 3'd1;

  // Next word to load: word 1 from ARM or after word 10, else the following word.
  // tow_q/sf_id_q already hold the new subframe's values when its HOW is loaded.
  always_comb begin
    word_sel = 4'd0;
    if (state_q == StRun && word_cnt_q != 4'd9) word_sel = word_cnt_q + 4'd1;
    word_data = 24'd0;
    if (word_sel == 4'd0) begin
      word_data = {Preamble, tlm_in, 2'b00};
    end else if (word_sel == 4'd1) begin
      word_data = {tow_q, 2'b00, sf_id_q, 2'b00};
    end
    word_tx = {word_data ^ {24{d30_q}}, gps_parity(word_data, d29_q, d30_q)};
  end

  always_comb begin
    state_d     = state_q;
    epoch_cnt_d = epoch_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    word_cnt_d  = word_cnt_q;
    sf_id_d     = sf_id_q;
    tow_d       = tow_q;
    tow_out_d   = tow_out_q;
    d29_d       = d29_q;
    d30_d       = d30_q;
    sr_d        = sr_q;
    msg_d       = msg_q;
    strobe_d    = 1'b0;
    sf_start_d  = 1'b0;
    load        = 1'b0;
    shift       = 1'b0;
    tx_bit      = 1'b0;

    if (!ena_in) begin
      // Disable wins over a coincident epoch; msg_out and tow_out keep their values.
      state_d     = StIdle;
      epoch_cnt_d = '0;
      bit_cnt_d   = 5'd0;
      word_cnt_d  = 4'd0;
      sf_id_d     = 3'd1;
      d29_d       = 1'b0;
      d30_d       = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          tow_d   = tow_init_in;
          state_d = StArm;
        end
        StArm: begin
          if (epoch_in) begin
            state_d     = StRun;
            epoch_cnt_d = '0;
            bit_cnt_d   = 5'd0;
            word_cnt_d  = 4'd0;
            load        = 1'b1;
            sf_start_d  = 1'b1;
            tow_out_d   = tow_q;
          end
        end
        StRun: begin
          if (epoch_in) begin
            if (epoch_cnt_q == EpochLast) begin
              epoch_cnt_d = '0;
              if (bit_cnt_q == 5'd29) begin
                bit_cnt_d  = 5'd0;
                word_cnt_d = word_sel;
                load       = 1'b1;
                if (word_cnt_q == 4'd9) begin
                  sf_start_d = 1'b1;
                  sf_id_d    = sf_id_inc;
                  tow_d      = tow_inc;
                  tow_out_d  = tow_inc;
                end
              end else begin
                bit_cnt_d = bit_cnt_q + 5'd1;
                shift     = 1'b1;
              end
            end else begin
              epoch_cnt_d = epoch_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (load) begin
      tx_bit = word_tx[29];
      sr_d   = {word_tx[28:0], 1'b0};
      d29_d  = word_tx[1];
      d30_d  = word_tx[0];
    end else if (shift) begin
      tx_bit = sr_q[29];
      sr_d   = {sr_q[28:0], 1'b0};
    end

    // Framing runs regardless of preset_in so switching modes keeps bit alignment.
    if (load || shift) begin
      msg_d    = preset_in ? tx_bit : ext_sync_q;
      strobe_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in_n) begin
      state_q     <= StIdle;
      epoch_cnt_q <= '0;
      bit_cnt_q   <= 5'd0;
      word_cnt_q  <= 4'd0;
      sf_id_q     <= 3'd1;
      tow_q       <= 17'd0;
      tow_out_q   <= 17'd0;
      d29_q       <= 1'b0;
      d30_q       <= 1'b0;
      sr_q        <= 30'd0;
      msg_q       <= 1'b0;
      strobe_q    <= 1'b0;
      sf_start_q  <= 1'b0;
      ext_meta_q  <= 1'b0;
      ext_sync_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      epoch_cnt_q <= epoch_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      sf_id_q     <= sf_id_d;
      tow_q       <= tow_d;
      tow_out_q   <= tow_out_d;
      d29_q       <= d29_d;
      d30_q       <= d30_d;
      sr_q        <= sr_d;
      msg_q       <= msg_d;
      strobe_q    <= strobe_d;
      sf_start_q  <= sf_start_d;
      ext_meta_q  <= ext_msg_in;
      ext_sync_q  <= ext_meta_q;
    end
  end

  assign msg_out            = msg_q;
  assign bit_strobe_out     = strobe_q;
  assign subframe_start_out = sf_start_q;
  assign tow_out            = tow_out_q;

endmodule

// File: tb/tb_nav_msg_gen.sv
// Scoreboard bench for nav_msg_gen: the driver pushes the expected bit, subframe
// flag, TOW and arrival cycle for every emitting epoch; the monitor pops and
// compares on each bit_strobe_out.
module tb_nav_msg_gen;

  localparam int unsigned Epb      = 4;
  localparam int unsigned TowMax   = 100799;
  localparam int          EpochGap = 4;

  logic        clk_in = 1'b0;
  logic        rst_in_n = 1'b0;
  logic        ena_in = 1'b0;
  logic        epoch_in = 1'b0;
  logic        preset_in = 1'b1;
  logic        ext_msg_in = 1'b0;
  logic [13:0] tlm_in = 14'd0;
  logic [16:0] tow_init_in = 17'd0;
  logic        msg_out, bit_strobe_out, subframe_start_out;
  logic [16:0] tow_out;

  nav_msg_gen #(
    .EPOCHS_PER_BIT(Epb),
    .TOW_MAX       (TowMax)
  ) dut (
    .clk_in            (clk_in),
    .rst_in_n          (rst_in_n),
    .ena_in            (ena_in),
    .epoch_in          (epoch_in),
    .preset_in         (preset_in),
    .ext_msg_in        (ext_msg_in),
    .tlm_in            (tlm_in),
    .tow_init_in       (tow_init_in),
    .msg_out           (msg_out),
    .bit_strobe_out    (bit_strobe_out),
    .subframe_start_out(subframe_start_out),
    .tow_out           (tow_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Parity equation bit lists (D25..D30), 0 = unused slot.
  int eqs [6][15] = '{
    '{1, 2, 3, 5, 6, 10, 11, 12, 13, 14, 17, 18, 20, 23, 0},
    '{2, 3, 4, 6, 7, 11, 12, 13, 14, 15, 18, 19, 21, 24, 0},
    '{1, 3, 4, 5, 7, 8, 12, 13, 14, 15, 16, 19, 20, 22, 0},
    '{2, 4, 5, 6, 8, 9, 13, 14, 15, 16, 17, 20, 21, 23, 0},
    '{1, 3, 5, 6, 7, 9, 10, 14, 15, 16, 17, 18, 21, 22, 24},
    '{3, 5, 6, 8, 9, 10, 11, 13, 15, 19, 22, 23, 24, 0, 0}
  };

  function automatic logic [5:0] ref_parity(input logic [23:0] data, input logic p29,
                                            input logic p30);
    logic [5:0] p;
    for (int k = 0; k < 6; k++) begin
      p[5-k] = (k == 1 || k == 3 || k == 4) ? p30 : p29;
      for (int j = 0; j < 15; j++)
        if (eqs[k][j] != 0) p[5-k] = p[5-k] ^ data[24 - eqs[k][j]];
    end
    return p;
  endfunction

  typedef struct {
    int          cyc;
    logic        msg;
    logic        sfs;
    logic [16:0] tow;
  } exp_t;

  exp_t exp_q[$];
  logic bit_log[$];
  int   sf_tow[$];
  int   n_strobe = 0;
  int   n_sfs    = 0;
  logic mon_en   = 1'b0;
  logic prev_msg = 1'b0;

  // Reference model state
  int          m_state = 0;  // 0 idle, 1 armed, 2 running
  int          m_ecnt, m_bit, m_word, m_emits;
  logic [2:0]  m_sf = 3'd1;
  logic [16:0] m_tow = 17'd0, m_tow_out = 17'd0;
  logic        m_d29 = 1'b0, m_d30 = 1'b0, m_msg = 1'b0;
  logic [29:0] m_cur = 30'd0;

  task automatic model_load();
    logic [23:0] data;
    data = 24'd0;
    if (m_word == 0) data = {8'b1000_1011, tlm_in, 2'b00};
    else if (m_word == 1) data = {m_tow, 2'b00, m_sf, 2'b00};
    m_cur = {data ^ {24{m_d30}}, ref_parity(data, m_d29, m_d30)};
    m_d29 = m_cur[1];
    m_d30 = m_cur[0];
  endtask

  task automatic model_clear();
    m_state = 0; m_ecnt = 0; m_bit = 0; m_word = 0; m_sf = 3'd1;
    m_d29 = 1'b0; m_d30 = 1'b0;
  endtask

  task automatic model_epoch();
    logic emit, sfs;
    exp_t e;
    emit = 1'b0;
    sfs  = 1'b0;
    if (m_state == 1) begin
      m_state = 2; m_ecnt = 0; m_bit = 0; m_word = 0;
      m_tow_out = m_tow; sfs = 1'b1; emit = 1'b1;
      model_load();
    end else if (m_state == 2) begin
      if (m_ecnt == Epb - 1) begin
        m_ecnt = 0;
        emit = 1'b1;
        if (m_bit == 29) begin
          m_bit = 0;
          if (m_word == 9) begin
            m_word = 0;
            m_sf = (m_sf == 3'd5) ? 3'd1 : m_sf + 3'd1;
            m_tow = (m_tow == 17'(TowMax)) ? 17'd0 : m_tow + 17'd1;
            m_tow_out = m_tow;
            sfs = 1'b1;
          end else begin
            m_word++;
          end
          model_load();
        end else begin
          m_bit++;
        end
      end else begin
        m_ecnt++;
      end
    end
    if (emit) begin
      m_msg = preset_in ? m_cur[29 - m_bit] : ext_msg_in;
      e.cyc = cyc + 1;
      e.msg = m_msg;
      e.sfs = sfs;
      e.tow = m_tow_out;
      exp_q.push_back(e);
      m_emits++;
    end
  endtask

  // Driver tasks: called at posedge+1, return at posedge+1.
  task automatic issue_epoch(input logic drop_ena);
    epoch_in = 1'b1;
    if (drop_ena) begin
      ena_in = 1'b0;
      model_clear();
    end else begin
      model_epoch();
    end
    @(posedge clk_in); #1;
    epoch_in = 1'b0;
    repeat (EpochGap - 1) begin @(posedge clk_in); #1; end
  endtask

  task automatic run_bits(input int n);
    int target, guard;
    target = m_emits + n;
    guard  = 0;
    while (m_emits < target && guard < 20000) begin
      issue_epoch(1'b0);
      guard++;
    end
  endtask

  task automatic enable(input logic [16:0] tow0);
    tow_init_in = tow0;
    ena_in      = 1'b1;
    m_state     = 1;
    m_tow       = tow0;
    @(posedge clk_in); #1;
  endtask

  task automatic disable_ena();
    ena_in = 1'b0;
    model_clear();
    @(posedge clk_in); #1;
  endtask

  task automatic pulse_reset(input string tag);
    mon_en   = 1'b0;
    ena_in   = 1'b0;
    rst_in_n = 1'b0;
    model_clear();
    m_tow = 17'd0; m_tow_out = 17'd0; m_msg = 1'b0;
    exp_q.delete();
    @(posedge clk_in); #1;
    rst_in_n = 1'b1;
    @(negedge clk_in);
    check({tag, "_msg_out"}, {31'd0, msg_out}, 32'd0);
    check({tag, "_bit_strobe"}, {31'd0, bit_strobe_out}, 32'd0);
    check({tag, "_sf_start"}, {31'd0, subframe_start_out}, 32'd0);
    check({tag, "_tow_out"}, {15'd0, tow_out}, 32'd0);
    @(posedge clk_in); #1;
    mon_en = 1'b1;
  endtask

  // Monitor: scoreboard pop on each strobe, plus strobe-qualified output changes.
  always @(negedge clk_in) begin
    exp_t e;
    if (mon_en) begin
      if (subframe_start_out) check("sf_start_with_strobe", {31'd0, bit_strobe_out}, 32'd1);
      if (msg_out !== prev_msg) check("msg_change_at_strobe", {31'd0, bit_strobe_out}, 32'd1);
      if (bit_strobe_out) begin
        n_strobe++;
        bit_log.push_back(msg_out);
        if (subframe_start_out) begin
          n_sfs++;
          sf_tow.push_back(int'(tow_out));
        end
        if (exp_q.size() == 0) begin
          check("strobe_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("strobe_cycle", 32'(cyc), 32'(e.cyc));
          check("msg_out", {31'd0, msg_out}, {31'd0, e.msg});
          check("sf_start", {31'd0, subframe_start_out}, {31'd0, e.sfs});
          check("tow_out", {15'd0, tow_out}, {15'd0, e.tow});
        end
      end
    end
    prev_msg = msg_out;
  end

  initial begin
    #3_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [29:0] w1, w1_exp;
    logic [39:0] ext_pat;
    logic [16:0] tow_dec;
    logic [2:0]  sf_dec;
    logic        inv;
    int          base, bidx, strobes0;

    @(posedge clk_in); #1;
    pulse_reset("reset");

    // Preamble word with tlm=0, tow=0, one full subframe.
    preset_in = 1'b1;
    tlm_in    = 14'd0;
    enable(17'd0);
    run_bits(300);
    @(negedge clk_in);
    w1 = 30'd0;
    for (int i = 0; i < 30; i++) w1 = {w1[28:0], bit_log[i]};
    w1_exp = {8'b1000_1011, 14'd0, 2'b00, 6'b010010};
    check("word1_bits", {2'b00, w1}, {2'b00, w1_exp});
    check("strobes_per_subframe", 32'(n_strobe), 32'd300);
    check("sf_start_pulses", 32'(n_sfs), 32'd1);

    // TOW wrap and subframe ID over three subframes.
    disable_ena();
    pulse_reset("reset2");
    bit_log.delete();
    sf_tow.delete();
    tlm_in = 14'h2A5C;
    enable(17'd100798);
    run_bits(900);
    @(negedge clk_in);
    check("sf_tow_count", 32'(sf_tow.size()), 32'd3);
    if (sf_tow.size() == 3) begin
      check("sf_tow_0", 32'(sf_tow[0]), 32'd100798);
      check("sf_tow_1", 32'(sf_tow[1]), 32'd100799);
      check("sf_tow_2", 32'(sf_tow[2]), 32'd0);
    end
    for (int k = 0; k < 3; k++) begin
      base = k * 300;
      if (bit_log.size() >= base + 60) begin
        inv = bit_log[base + 29];
        tow_dec = 17'd0;
        for (int i = 0; i < 17; i++) tow_dec = {tow_dec[15:0], bit_log[base + 30 + i] ^ inv};
        sf_dec = {bit_log[base + 49], bit_log[base + 50], bit_log[base + 51]} ^ {3{inv}};
        check("how_sf_id", {29'd0, sf_dec}, 32'(k + 1));
        check("how_tow", {15'd0, tow_dec}, (k == 2) ? 32'd0 : 32'(100798 + k));
      end
    end

    // External bit pass-through, toggled mid-bit.
    ext_pat   = 40'hA5_3C_96_0F_E1;
    preset_in = 1'b0;
    bidx      = 0;
    for (int g = 0; g < 400 && bidx < 40; g++) begin
      if (m_ecnt == 1) ext_msg_in = ~ext_pat[39 - bidx];
      if (m_ecnt == 2) ext_msg_in = ext_pat[39 - bidx];
      if (m_ecnt == Epb - 1) bidx++;
      issue_epoch(1'b0);
    end
    preset_in = 1'b1;
    run_bits(40);

    // Drop enable on the epoch that would emit word 4, bit 12.
    for (int g = 0; g < 20000 && !(m_word == 3 && m_bit == 11); g++) issue_epoch(1'b0);
    for (int g = 0; g < 10 && m_ecnt != Epb - 1; g++) issue_epoch(1'b0);
    strobes0 = n_strobe;
    issue_epoch(1'b1);
    repeat (6) issue_epoch(1'b0);
    check("idle_no_strobes", 32'(n_strobe - strobes0), 32'd0);
    check("idle_msg_held", {31'd0, msg_out}, {31'd0, m_msg});
    check("idle_tow_held", {15'd0, tow_out}, {15'd0, m_tow_out});

    // Restart from word 1, bit 0 with cleared D29*/D30*.
    tlm_in = 14'h1234;
    enable(17'h18000);
    run_bits(32);
    repeat (2) issue_epoch(1'b0);
    @(negedge clk_in);
    check("pre_reset_tow", {15'd0, tow_out}, 32'h18000);

    // Reset mid-word.
    @(posedge clk_in); #1;
    pulse_reset("midword_reset");

    repeat (10) @(posedge clk_in);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
